// File: rtl/system.sv
// rtl/system.sv - multi-lane FP32 multiplier sharing one register file
// Each lane reads two operands, multiplies them into a registered result, and may write back.
module system #(
    parameter int PARALLEL_ORDER = 2,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DATA_WIDTH = 32
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [PARALLEL_ORDER-1:0]                     r_valid1,
    input  logic [PARALLEL_ORDER-1:0]                     r_valid2,
    input  logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0] r_addr1,
    input  logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0] r_addr2,
    input  logic [PARALLEL_ORDER-1:0]                     w_valid,
    input  logic [PARALLEL_ORDER-1:0][REG_ADDR_WIDTH-1:0] w_addr,
    input  logic [PARALLEL_ORDER-1:0]                     w_sel,
    input  logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0] w_data,
    output logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0] out
);

    localparam int DEPTH = 2 ** REG_ADDR_WIDTH;

    logic [REG_DATA_WIDTH-1:0] rf [DEPTH];
    logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0] rd1;
    logic [PARALLEL_ORDER-1:0][REG_DATA_WIDTH-1:0] rd2;

    // Zero/denormal operands flush to zero and take priority over Inf/NaN.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [9:0]  e_sum;
        logic [22:0] m;
        logic [31:0] r;
        s     = a[31] ^ b[31];
        p     = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e_sum = {2'b00, a[30:23]} + {2'b00, b[30:23]};
        if (p[47]) begin
            m     = p[46:24];
            e_sum = e_sum + 10'd1;
        end else begin
            m     = p[45:23];
        end
        // e_sum holds the biased result exponent plus 127.
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
            r = {s, 31'b0};
        else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
            r = {s, 8'hFF, 23'b0};
        else if (e_sum >= 10'd382)
            r = {s, 8'hFF, 23'b0};
        else if (e_sum <= 10'd127)
            r = {s, 31'b0};
        else
            r = {s, 8'(e_sum - 10'd127), m};
        return r;
    endfunction

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < PARALLEL_ORDER; i++) begin
            rd1[i] = rf[r_addr1[i]];
            rd2[i] = rf[r_addr2[i]];
        end
    end

    // Ascending lane order lets the highest lane win a same-address write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++)
                rf[k] <= '0;
            out <= '0;
        end else begin
            for (int i = 0; i < PARALLEL_ORDER; i++) begin
                if (r_valid1[i] && r_valid2[i])
                    out[i] <= fmul(rd1[i], rd2[i]);
            end
            for (int i = 0; i < PARALLEL_ORDER; i++) begin
                if (w_valid[i])
                    rf[w_addr[i]] <= w_sel[i] ? out[i] : w_data[i];
            end
        end
    end

endmodule

// File: tb/tb_system.sv
// tb/tb_system.sv - scoreboard bench for system with a behavioural FP32 multiply model
module tb_system;
    localparam int P  = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef logic [P-1:0][DW-1:0] vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [P-1:0]         r_valid1, r_valid2, w_valid, w_sel;
    logic [P-1:0][AW-1:0] r_addr1, r_addr2, w_addr;
    logic [P-1:0][DW-1:0] w_data;
    vec_t                 out;

    system #(.PARALLEL_ORDER(P), .REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .r_valid1(r_valid1), .r_valid2(r_valid2),
        .r_addr1(r_addr1), .r_addr2(r_addr2),
        .w_valid(w_valid), .w_addr(w_addr), .w_sel(w_sel), .w_data(w_data),
        .out(out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [31:0] rf_m [32];
    vec_t out_m;
    vec_t exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        logic    s;
        int      ea, eb, e;
        longint  p, m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 || eb == 0) return {s, 31'b0};
        if (ea == 255 || eb == 255) return {s, 8'hFF, 23'b0};
        p = (longint'(8388608) + longint'(a[22:0])) * (longint'(8388608) + longint'(b[22:0]));
        m = p / 8388608;
        e = ea + eb - 127;
        if (m >= 16777216) begin
            m = m / 2;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'b0};
        if (e <= 0) return {s, 31'b0};
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        int unsigned sel;
        logic [7:0] e;
        sel = $urandom_range(0, 9);
        case (sel)
            0: e = 8'd0;
            1: e = 8'hFF;
            2: e = 8'($urandom_range(1, 20));
            3: e = 8'($urandom_range(235, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic idle();
        r_valid1 = '0; r_valid2 = '0; w_valid = '0; w_sel = '0;
        r_addr1 = '0; r_addr2 = '0; w_addr = '0; w_data = '0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) rf_m[k] = '0;
        out_m = '0;
        exp_q.delete();
    endtask

    // Apply current inputs to the model, queue the expected outputs, advance one cycle.
    task automatic step();
        vec_t nxt;
        nxt = out_m;
        for (int i = 0; i < P; i++)
            if (r_valid1[i] && r_valid2[i])
                nxt[i] = fmul_ref(rf_m[r_addr1[i]], rf_m[r_addr2[i]]);
        for (int i = 0; i < P; i++)
            if (w_valid[i])
                rf_m[w_addr[i]] = w_sel[i] ? out_m[i] : w_data[i];
        out_m = nxt;
        exp_q.push_back(out_m);
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int lane, input logic [4:0] a, input logic [31:0] d);
        w_valid[lane] = 1'b1; w_sel[lane] = 1'b0; w_addr[lane] = a; w_data[lane] = d;
    endtask

    task automatic rd(input int lane, input logic [4:0] a1, input logic [4:0] a2);
        r_valid1[lane] = 1'b1; r_valid2[lane] = 1'b1; r_addr1[lane] = a1; r_addr2[lane] = a2;
    endtask

    always @(negedge clk) begin
        vec_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < P; i++)
                chk($sformatf("scoreboard_out%0d", i), out[i], e[i]);
        end
    end

    initial begin
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out0", out[0], 32'h0);
        chk("reset_out1", out[1], 32'h0);
        rst_n = 1'b1;

        idle(); rd(0, 0, 0); rd(1, 0, 0); step();
        chk("zero_read_out0", out[0], 32'h0);

        idle(); wr(0, 1, 32'h40A00000); wr(1, 2, 32'h40800000); step();
        idle(); rd(1, 1, 2); step();
        chk("mul_5x4", out[1], 32'h41A00000);
        chk("lane0_unchanged", out[0], 32'h0);

        idle(); w_valid[1] = 1'b1; w_sel[1] = 1'b1; w_addr[1] = 3; step();
        idle(); rd(1, 3, 1); step();
        chk("writeback_20x5", out[1], 32'h42C80000);

        idle(); wr(0, 7, 32'h3F800000); wr(1, 7, 32'h40000000); step();
        idle(); rd(0, 7, 7); step();
        chk("collision_lane1_wins", out[0], 32'h40800000);

        idle(); wr(0, 8, 32'h7F000000); wr(1, 9, 32'h00800000); step();
        idle(); wr(0, 10, 32'hC0000000); wr(1, 11, 32'h40400000); step();
        idle(); rd(0, 8, 8); rd(1, 9, 9); step();
        chk("overflow_inf", out[0], 32'h7F800000);
        chk("underflow_zero", out[1], 32'h0);
        idle(); rd(0, 10, 11); step();
        chk("neg2_x_3", out[0], 32'hC0C00000);
        idle(); r_valid1[0] = 1'b1; r_addr1[0] = 8; r_addr2[0] = 8; step();
        chk("single_valid_holds", out[0], 32'hC0C00000);

        for (int n = 0; n < 400; n++) begin
            idle();
            r_valid1 = P'($urandom); r_valid2 = P'($urandom | $urandom);
            w_valid = P'($urandom); w_sel = P'($urandom);
            for (int i = 0; i < P; i++) begin
                r_addr1[i] = AW'($urandom); r_addr2[i] = AW'($urandom);
                w_addr[i] = AW'($urandom); w_data[i] = rand_fp();
            end
            step();
        end

        idle(); wr(0, 1, 32'h40A00000); wr(1, 2, 32'h40800000); step();
        idle(); w_valid[0] = 1'b1; w_addr[0] = 3; w_data[0] = 32'h3F800000; rd(0, 1, 2); rd(1, 1, 1); step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_out0", out[0], 32'h0);
        chk("async_out1", out[1], 32'h0);
        for (int k = 1; k <= 3; k++)
            chk($sformatf("async_rf%0d", k), dut.rf[k], 32'h0);
        model_reset();
        idle();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        idle(); rd(0, 1, 2); rd(1, 3, 3); step();

        for (int n = 0; n < 100; n++) begin
            idle();
            r_valid1 = P'($urandom); r_valid2 = P'($urandom);
            w_valid = P'($urandom); w_sel = P'($urandom);
            for (int i = 0; i < P; i++) begin
                r_addr1[i] = AW'($urandom_range(0, 7)); r_addr2[i] = AW'($urandom_range(0, 7));
                w_addr[i] = AW'($urandom_range(0, 7)); w_data[i] = rand_fp();
            end
            step();
        end

        idle();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
